// File: rtl/priority_match_unit_pkg.sv
// Shared constants and helpers for the priority match unit.
package priority_match_unit_pkg;

    localparam int HIT_CNT_W = 16;
    localparam int CODE_NONE = 0;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/priority_match_unit_prio_enc.sv
// Lowest-index-wins priority encoder: hit vector -> (lowest set bit + 1), or 0 if none.
module prio_enc
    import priority_match_unit_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = clog2(N + 1)
) (
    input  logic [N-1:0]  hit,
    output logic [CW-1:0] code
);

    // Scan from the top down so the lowest set bit is the last to write the code.
    always_comb begin
        code = CW'(CODE_NONE);
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                code = CW'(i + 1);
            end else begin
                code = code;
            end
        end
    end

endmodule

// File: rtl/priority_match_unit.sv
// Registered N-channel pattern matcher with valid/ready handshake and saturating hit counter.
module priority_match_unit
    import priority_match_unit_pkg::*;
#(
    parameter int  W  = 8,
    parameter int  N  = 3,
    localparam int IW = (clog2(N) < 1) ? 1 : clog2(N),
    localparam int CW = clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_idx,
    input  logic [W-1:0]         cfg_data,
    input  logic                 cfg_en,
    input  logic                 cnt_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_code,
    output logic [N-1:0]         out_hit_mask,
    output logic [HIT_CNT_W-1:0] hit_cnt
);

    logic [W-1:0]  pattern_r [N];
    logic [N-1:0]  en_r;
    logic [N-1:0]  hit_s;
    logic [CW-1:0] code_s;
    logic          accept_s;
    logic          deliver_s;

    assign in_ready  = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign deliver_s = out_valid && out_ready;

    // Pattern/enable register file; out-of-range indices match no channel and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pattern_r[i] <= '0;
            end
            en_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cfg_we && (cfg_idx == IW'(i))) begin
                    pattern_r[i] <= cfg_data;
                    en_r[i]      <= cfg_en;
                end else begin
                    pattern_r[i] <= pattern_r[i];
                    en_r[i]      <= en_r[i];
                end
            end
        end
    end

    // Equality comparators against the pre-write register contents.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < N; i++) begin
            hit_s[i] = en_r[i] && (pattern_r[i] == in_data);
        end
    end

    prio_enc #(
        .N  (N),
        .CW (CW)
    ) u_prio_enc (
        .hit  (hit_s),
        .code (code_s)
    );

    // Single output register; code and mask keep their last values once consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_code     <= '0;
            out_hit_mask <= '0;
        end else if (accept_s) begin
            out_valid    <= 1'b1;
            out_code     <= code_s;
            out_hit_mask <= hit_s;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end else begin
            out_valid    <= out_valid;
        end
    end

    // Saturating count of delivered matching results; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
        end else if (deliver_s && (out_code != CW'(CODE_NONE)) && (hit_cnt != {HIT_CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + {{(HIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hit_cnt <= hit_cnt;
        end
    end

endmodule
